// File: rtl/adder8_pkg.sv
// -----------------------------------------------------------------------------
// adder8_pkg
// Shared definitions for the adder8 result FIFO:
//   DEPTH_DEFAULT : default number of result entries
//   ENTRY_W       : stored entry width (sum[8], carry, overflow, mode)
//   entry_t       : packed entry layout, sum index 0 is the MSB
//   fifo_state_t  : occupancy state of the result FIFO
// -----------------------------------------------------------------------------
package adder8_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int ENTRY_W       = 11;

  typedef struct packed {
    logic [0:7] sum;
    logic       carry;
    logic       overflow;
    logic       mode;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/adder8_result_mem.sv
// -----------------------------------------------------------------------------
// adder8_result_mem
// DEPTH x ENTRY_W storage with one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : combinational read data at raddr
// -----------------------------------------------------------------------------
module adder8_result_mem
  import adder8_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adder8_result_fifo.sv
// -----------------------------------------------------------------------------
// adder8_result_fifo
// Buffers adder8 results (sum, carry, overflow, mode) in push order and
// keeps overflow statistics over accepted results.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : producer handshake; push when both are high
//   in_sum, in_carry,
//   in_overflow, in_mode: result fields (in_sum index 0 is the MSB)
//   out_valid/out_ready : consumer handshake; pop when both are high
//   out_sum, out_carry,
//   out_overflow,out_mode: head entry fields, zero while empty
//   count               : entries held
//   ovf_sticky          : set by any accepted result with overflow
//   ovf_count           : saturating count of accepted overflow results
//   clr_stats           : synchronous clear of the statistics
// -----------------------------------------------------------------------------
module adder8_result_fifo
  import adder8_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:7]    in_sum,
  input  logic          in_carry,
  input  logic          in_overflow,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:7]    out_sum,
  output logic          out_carry,
  output logic          out_overflow,
  output logic          out_mode,
  output logic [CW-1:0] count,
  output logic          ovf_sticky,
  output logic [7:0]    ovf_count,
  input  logic          clr_stats
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_state_t   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, push_ovf;
  entry_t        wr_entry, rd_entry;
  logic          sticky_q;
  logic [7:0]    ovf_cnt_q;

  function automatic logic [7:0] ovf_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Handshakes: in_ready drops as soon as rst rises, before any edge.
  assign in_ready  = (state_q != ST_FULL) && !rst;
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push_ovf  = push && in_overflow;

  assign wr_entry = '{sum: in_sum, carry: in_carry, overflow: in_overflow, mode: in_mode};

  adder8_result_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Head is read straight from storage; gating keeps outputs at zero while
  // empty, including during reset when storage still holds stale data.
  assign out_sum      = out_valid ? rd_entry.sum      : '0;
  assign out_carry    = out_valid ? rd_entry.carry    : 1'b0;
  assign out_overflow = out_valid ? rd_entry.overflow : 1'b0;
  assign out_mode     = out_valid ? rd_entry.mode     : 1'b0;
  assign count        = count_q;
  assign ovf_sticky   = sticky_q;
  assign ovf_count    = ovf_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && (count_q == CW'(DEPTH - 1))) begin
          state_d = ST_FULL;
        end else if (pop && !push && (count_q == CW'(1))) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A coincident overflow push wins over clr_stats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q  <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      if (push_ovf) begin
        sticky_q <= 1'b1;
      end else if (clr_stats) begin
        sticky_q <= 1'b0;
      end
      if (clr_stats) begin
        ovf_cnt_q <= push_ovf ? 8'd1 : 8'd0;
      end else if (push_ovf) begin
        ovf_cnt_q <= ovf_sat_inc(ovf_cnt_q);
      end
    end
  end

endmodule

// File: tb/tb_adder8_result_fifo.sv
module tb_adder8_result_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [0:7]    in_sum = '0;
  logic          in_carry = 1'b0, in_overflow = 1'b0, in_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [0:7]    out_sum;
  logic          out_carry, out_overflow, out_mode;
  logic [CW-1:0] count;
  logic          ovf_sticky;
  logic [7:0]    ovf_count;
  logic          clr_stats = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of {sum, carry, overflow, mode} plus statistics.
  logic [10:0] mq[$];
  logic        m_sticky = 1'b0;
  int          m_ovf_cnt = 0;
  int          max_count = 0;

  adder8_result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_overflow(in_overflow), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_overflow(out_overflow), .out_mode(out_mode),
    .count(count), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [10:0] h;
    h = (mq.size() > 0) ? mq[0] : 11'd0;
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check_eq({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < DEPTH));
    check_eq({tag, ".count"},     32'(count),     32'(mq.size()));
    check_eq({tag, ".head"}, 32'({out_sum, out_carry, out_overflow, out_mode}), 32'(h));
    check_eq({tag, ".sticky"},    32'(ovf_sticky), 32'(m_sticky));
    check_eq({tag, ".ovf_cnt"},   32'(ovf_count),  32'(m_ovf_cnt));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic cycle(input logic v, input logic [7:0] s, input logic c, input logic o,
                       input logic m, input logic rdy, input logic clr, input string tag);
    logic acc_push, acc_pop;
    in_valid = v; in_sum = s; in_carry = c; in_overflow = o; in_mode = m;
    out_ready = rdy; clr_stats = clr;
    acc_push = v && (mq.size() < DEPTH);
    acc_pop  = rdy && (mq.size() > 0);
    @(posedge clk);
    if (acc_pop) void'(mq.pop_front());
    if (acc_push) mq.push_back({s, c, o, m});
    if (acc_push && o) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
    if (clr) m_ovf_cnt = (acc_push && o) ? 1 : 0;
    else if (acc_push && o && m_ovf_cnt < 255) m_ovf_cnt++;
    if (mq.size() > max_count) max_count = mq.size();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0, 1, 0, "drain");
  endtask

  task automatic model_reset();
    mq.delete();
    m_sticky = 1'b0;
    m_ovf_cnt = 0;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst.in_ready", 32'(in_ready), 32'd0);
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.count", 32'(count), 32'd0);
    check_eq("rst.stats", 32'({ovf_sticky, ovf_count}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_all("post_rst");

    // Single push becomes visible the following cycle
    cycle(1, 8'h03, 1, 0, 1, 0, 0, "push1");
    check_eq("push1.sum", 32'(out_sum), 32'h03);
    check_eq("push1.carry", 32'(out_carry), 32'd1);
    check_eq("push1.count", 32'(count), 32'd1);
    idle(1);

    // Fill, overfill attempt, drain in order
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, i[0], 0, 0, "fill");
    check_eq("full.count", 32'(count), 32'd4);
    check_eq("full.in_ready", 32'(in_ready), 32'd0);
    cycle(1, 8'h55, 1, 0, 0, 0, 0, "overfill");
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain.sum", 32'(out_sum), 32'(i));
      cycle(0, 8'h00, 0, 0, 0, 1, 0, "drain");
    end
    check_eq("drained.out_valid", 32'(out_valid), 32'd0);

    // FULL with push and pop together: only the pop happens
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h10 + i), 0, 0, 0, 0, 0, "fill2");
    cycle(1, 8'hAA, 0, 0, 0, 1, 0, "full_pp");
    check_eq("full_pp.count", 32'(count), 32'd3);
    cycle(1, 8'hAB, 1, 0, 1, 0, 0, "refill");
    check_eq("refill.count", 32'(count), 32'd4);
    idle(4);

    // Overflow statistics
    for (int i = 0; i < 3; i++) cycle(1, 8'h80, 0, 1, 0, 1, 0, "ovf");
    check_eq("ovf.sticky", 32'(ovf_sticky), 32'd1);
    check_eq("ovf.count", 32'(ovf_count), 32'd3);
    cycle(1, 8'h80, 0, 1, 0, 1, 1, "clr_ovf");
    check_eq("clr_ovf.sticky", 32'(ovf_sticky), 32'd1);
    check_eq("clr_ovf.count", 32'(ovf_count), 32'd1);
    cycle(0, 8'h00, 0, 0, 0, 1, 1, "clr");
    check_eq("clr.stats", 32'({ovf_sticky, ovf_count}), 32'd0);

    // Asynchronous reset with two entries held
    cycle(1, 8'h21, 0, 1, 0, 0, 0, "hold");
    cycle(1, 8'h22, 1, 0, 1, 0, 0, "hold");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst.out_valid", 32'(out_valid), 32'd0);
    check_eq("arst.count", 32'(count), 32'd0);
    check_eq("arst.in_ready", 32'(in_ready), 32'd0);
    check_eq("arst.head", 32'({out_sum, out_carry, out_overflow, out_mode}), 32'd0);
    check_eq("arst.stats", 32'({ovf_sticky, ovf_count}), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    rst = 1'b0;
    cycle(1, 8'h31, 1, 0, 0, 0, 0, "after_rst");
    check_eq("after_rst.sum", 32'(out_sum), 32'h31);
    cycle(1, 8'h32, 0, 0, 1, 1, 0, "after_rst2");
    idle(2);

    // Saturation with continuous pop
    max_count = 0;
    for (int i = 0; i < 300; i++) cycle(1, 8'h80, 0, 1, 0, 1, 0, "sat");
    check_eq("sat.ovf_count", 32'(ovf_count), 32'd255);
    check_eq("sat.max_count_le1", 32'(max_count <= 1), 32'd1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
